rmii_rx: RTL

- RMII receive front end. Converts LAN8720 RMII dibits (RXD[1:0], CRS_DV, RXER) at 50 MHz into a byte stream for the Ethernet frame parser.
- Locks byte alignment on the SFD and emits the SFD byte 0xD5 first, then every frame byte LSB-first-assembled, including the FCS.
- Flags frame start, frame end and frame errors.
- Supports 100 Mb/s mode only.

---
 rtl/rmii_rx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/rmii_rx.sv
// RMII receive front end: turns 100 Mb/s RMII dibits into an SFD-aligned byte stream with frame start/end/error flags.
// Latency: a byte is presented 3 clocks after its 4th dibit is sampled; frame end follows the last byte by >= 1 clock.
// No backpressure: the PHY cannot be stalled, so the consumer must accept one byte every 4 clocks.
module rmii_rx #(
  parameter int MIN_PREAMBLE_DIBITS = 4,
  parameter int MAX_FRAME_BYTES     = 1522
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rmii_crs_dv,
  input  logic [1:0] rmii_rxd,
  input  logic       rmii_rx_er,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       rx_frame_start,
  output logic       rx_frame_end,
  output logic       rx_frame_error,
  output logic       rx_active
);

  localparam logic [4:0]  MIN_PRE   = 5'(MIN_PREAMBLE_DIBITS);
  localparam logic [10:0] MAX_BYTES = 11'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;

  // Input pipeline: S is the first register, D the second; decisions act on D, S is lookahead.
  logic [1:0] s_rxd, d_rxd;
  logic       s_crs, d_crs;
  logic       s_er,  d_er;

  state_t      state;
  logic        armed;
  logic [4:0]  pre_cnt;
  logic [1:0]  dibit_cnt;
  logic [10:0] byte_cnt;
  logic        err;
  logic [7:0]  shift;

  // Decision-stage results, re-registered once more to form the outputs.
  logic       emit_vld;
  logic [7:0] emit_byte;
  logic       emit_start;
  logic       emit_end;
  logic       emit_err;

  // Two-stage input register on all PHY signals.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_rxd <= 2'b00;
      s_crs <= 1'b0;
      s_er  <= 1'b0;
      d_rxd <= 2'b00;
      d_crs <= 1'b0;
      d_er  <= 1'b0;
    end else begin
      s_rxd <= rmii_rxd;
      s_crs <= rmii_crs_dv;
      s_er  <= rmii_rx_er;
      d_rxd <= s_rxd;
      d_crs <= s_crs;
      d_er  <= s_er;
    end
  end

  // Receive FSM: preamble/SFD hunt, byte assembly, end-of-frame detection with CRS_DV drain tolerance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      armed      <= 1'b0;
      pre_cnt    <= 5'd0;
      dibit_cnt  <= 2'd0;
      byte_cnt   <= 11'd0;
      err        <= 1'b0;
      shift      <= 8'h00;
      emit_vld   <= 1'b0;
      emit_byte  <= 8'h00;
      emit_start <= 1'b0;
      emit_end   <= 1'b0;
      emit_err   <= 1'b0;
    end else begin
      emit_vld   <= 1'b0;
      emit_start <= 1'b0;
      emit_end   <= 1'b0;
      emit_err   <= 1'b0;
      case (state)
        IDLE: begin
          // Only a carrier that rises after a quiet period starts a frame,
          // so the tail of a frame cut by reset or a bad preamble is ignored.
          if (!d_crs) begin
            armed <= 1'b1;
          end else if (armed) begin
            state   <= PREAMBLE;
            pre_cnt <= 5'd0;
          end
        end
        PREAMBLE: begin
          if (!d_crs) begin
            state <= IDLE;
          end else if (d_rxd == 2'b01) begin
            if (pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
          end else if (d_rxd == 2'b00 && pre_cnt == 5'd0) begin
            state <= PREAMBLE;
          end else if (d_rxd == 2'b11 && pre_cnt >= MIN_PRE) begin
            emit_vld   <= 1'b1;
            emit_byte  <= 8'hD5;
            emit_start <= 1'b1;
            dibit_cnt  <= 2'd0;
            byte_cnt   <= 11'd0;
            err        <= 1'b0;
            state      <= DATA;
          end else begin
            state <= IDLE;
            armed <= 1'b0;
          end
        end
        DATA: begin
          if (!d_crs && !s_crs) begin
            // Two low samples in a row: the carrier is really gone.
            emit_end <= 1'b1;
            emit_err <= err | (dibit_cnt != 2'd0);
            state    <= IDLE;
            armed    <= 1'b1;
          end else begin
            // D.crs_dv low with S.crs_dv high is the drain toggle; the dibit is still data.
            shift     <= {d_rxd, shift[7:2]};
            dibit_cnt <= dibit_cnt + 2'd1;
            if (d_crs && d_er) err <= 1'b1;
            if (dibit_cnt == 2'd3) begin
              if (byte_cnt < MAX_BYTES) begin
                emit_vld  <= 1'b1;
                emit_byte <= {d_rxd, shift[7:2]};
                byte_cnt  <= byte_cnt + 11'd1;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register; rx_byte holds its last value between pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_byte        <= 8'h00;
      rx_byte_valid  <= 1'b0;
      rx_frame_start <= 1'b0;
      rx_frame_end   <= 1'b0;
      rx_frame_error <= 1'b0;
      rx_active      <= 1'b0;
    end else begin
      if (emit_vld) rx_byte <= emit_byte;
      rx_byte_valid  <= emit_vld;
      rx_frame_start <= emit_start;
      rx_frame_end   <= emit_end;
      rx_frame_error <= emit_err;
      rx_active      <= (state != IDLE);
    end
  end

endmodule
